// File: rtl/ks_byte_serial_seq.sv
// Byte-serial ADD/SUB sequencer feeding an external combinational 8-bit adder slice.
// The slice carry is chained byte to byte, LSB first.
module ks_byte_serial_seq #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   in_a,
   input  logic [8*NBYTES-1:0]   in_b,
   input  logic                  in_cin,
   input  logic                  in_sub,
   output logic [7:0]            add_x1,
   output logic [7:0]            add_x2,
   output logic                  add_cin,
   input  logic [7:0]            add_s,
   input  logic                  add_cout,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   out_sum,
   output logic                  out_cout,
   output logic                  out_ovf
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                     state;
   logic [IW-1:0]              idx;
   logic                       carry_reg;
   logic [NBYTES-1:0][7:0]     a_reg;
   logic [NBYTES-1:0][7:0]     b_reg;
   logic [NBYTES-1:0][7:0]     sum_reg;
   logic                       ovf_byte;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_sum   = W'(sum_reg);

   // Sign rule applied to the top byte; b_reg already holds the effective B.
   assign ovf_byte = (a_reg[NBYTES-1][7] == b_reg[NBYTES-1][7])
                   & (add_s[7] != a_reg[NBYTES-1][7]);

   always_comb begin
      add_x1  = 8'd0;
      add_x2  = 8'd0;
      add_cin = 1'b0;
      if (state == RUN) begin
         add_x1  = a_reg[idx];
         add_x2  = b_reg[idx];
         add_cin = carry_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= in_a;
                  b_reg     <= in_sub ? ~in_b : in_b;
                  carry_reg <= in_sub ? 1'b1 : in_cin;
                  idx       <= '0;
                  sum_reg   <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               sum_reg[idx] <= add_s;
               carry_reg    <= add_cout;
               if (idx == LAST) begin
                  out_cout <= add_cout;
                  out_ovf  <= ovf_byte;
                  state    <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ks_byte_serial_seq.sv
// Bench for ks_byte_serial_seq with a behavioural 8-bit slice and
// an arithmetic reference model of the full-width ADD/SUB.
module tb_ks_byte_serial_seq;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_cin;
   logic          in_sub;
   logic [7:0]    add_x1;
   logic [7:0]    add_x2;
   logic          add_cin;
   logic [7:0]    add_s;
   logic          add_cout;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_ovf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign {add_cout, add_s} = {1'b0, add_x1} + {1'b0, add_x2} + {8'd0, add_cin};

   ks_byte_serial_seq #(.NBYTES(NB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .add_x1    (add_x1),
      .add_x2    (add_x2),
      .add_cin   (add_cin),
      .add_s     (add_s),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: full-width integer arithmetic, signed overflow from true value.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin,
                        output logic [W-1:0] s, output logic co,
                        output logic ov);
      longint ua, ub, full, sa, sb, strue, sres;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         full  = ua - ub;
         co    = (ua >= ub);
         strue = sa - sb;
      end else begin
         full  = ua + ub + longint'(cin);
         co    = (full >= (64'sd1 <<< W));
         strue = sa + sb + longint'(cin);
      end
      s    = full[W-1:0];
      sres = longint'($signed(s));
      ov   = (sres != strue);
   endtask

   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
      int k;
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_cin   = cin;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = $urandom;
      in_b     = $urandom;
   endtask

   task automatic finish(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin, input int bp,
                         input logic hold, input logic [W-1:0] na,
                         input logic [W-1:0] nb);
      logic [W-1:0] es, be, lo;
      logic         eco, eov, c0;
      logic [63:0]  part;
      model(a, b, sub, cin, es, eco, eov);
      be = sub ? ~b : b;
      c0 = sub ? 1'b1 : cin;
      for (int i = 0; i < NB; i++) begin
         lo   = (i == 0) ? '0 : W'((64'd1 << (8 * i)) - 1);
         part = 64'(a & lo) + 64'(be & lo) + 64'(c0);
         check("run_x1", 64'(add_x1), 64'(a[8*i +: 8]));
         check("run_x2", 64'(add_x2), 64'(be[8*i +: 8]));
         check("run_cin", 64'(add_cin), 64'(part[8*i]));
         check("run_valid", 64'(out_valid), 64'd0);
         check("run_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      check("done_valid", 64'(out_valid), 64'd1);
      check("done_sum", 64'(out_sum), 64'(es));
      check("done_cout", 64'(out_cout), 64'(eco));
      check("done_ovf", 64'(out_ovf), 64'(eov));
      check("done_x1", 64'({add_x1, add_x2, add_cin}), 64'd0);
      if (bp > 0) begin
         out_ready = 1'b0;
         if (hold) begin
            in_a     = na;
            in_b     = nb;
            in_sub   = 1'b0;
            in_cin   = 1'b0;
            in_valid = 1'b1;
         end
         for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_ready", 64'(in_ready), 64'd0);
            check("bp_sum", 64'(out_sum), 64'(es));
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("idle_valid", 64'(out_valid), 64'd0);
      check("idle_ready", 64'(in_ready), 64'd1);
      check("idle_hold_sum", 64'(out_sum), 64'(es));
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic sub, input logic cin, input int bp);
      start(a, b, sub, cin);
      finish(a, b, sub, cin, bp, 1'b0, '0, '0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rs, rc;
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_a      = 32'h1234_5678;
      in_b      = 32'h1111_1111;
      in_cin    = 1'b1;
      in_sub    = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_sum", 64'(out_sum), 64'd0);
      check("rst_add", 64'({add_x1, add_x2, add_cin}), 64'd0);
      check("rst_flags", 64'({out_cout, out_ovf}), 64'd0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 64'(in_ready), 64'd1);

      op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
      op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 0);
      op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
      op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 0);
      op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 0);

      // Backpressure with a new op waiting, which is taken right after release.
      start(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0);
      finish(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 3, 1'b1,
             32'hDEAD_BEEF, 32'h0101_0101);
      check("bp_next_valid_held", 64'(in_valid), 64'd1);
      start(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0);
      finish(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0, 0, 1'b0, '0, '0);

      // Reset in the middle of RUN aborts the op.
      start(32'hAAAA_5555, 32'h1357_9BDF, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_ready", 64'(in_ready), 64'd1);
      check("abort_sum", 64'(out_sum), 64'd0);
      for (int i = 0; i < NB + 2; i++) begin
         check("abort_no_valid", 64'(out_valid), 64'd0);
         @(negedge clk);
      end
      op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         if (n % 8 == 0) rb = ra;
         op(ra, rb, rs, rc, $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
